// File: rtl/ahb_bus_arbiter_2m.sv
// Two-master AHB-lite arbiter with address-phase and write-data multiplexing.
// Optional build macro AHB_ARB_RR_EN: round-robin between contending masters.
module ahb_bus_arbiter_2m #(
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_BEATS      = 8,
  parameter int unsigned CNT_W          = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HBUSREQ_M0,
  input  logic        HBUSREQ_M1,
  input  logic        HLOCK_M0,
  input  logic        HLOCK_M1,
  output logic        HGRANT_M0,
  output logic        HGRANT_M1,
  input  logic [31:0] HADDR_M0,
  input  logic [31:0] HADDR_M1,
  input  logic [1:0]  HTRANS_M0,
  input  logic [1:0]  HTRANS_M1,
  input  logic        HWRITE_M0,
  input  logic        HWRITE_M1,
  input  logic [2:0]  HSIZE_M0,
  input  logic [2:0]  HSIZE_M1,
  input  logic [31:0] HWDATA_M0,
  input  logic [31:0] HWDATA_M1,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HMASTER,
  output logic        HMASTLOCK
);

  localparam logic             DEF_M    = 1'(DEFAULT_MASTER);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BEAT_LIM = CNT_W'(MAX_BEATS);
  localparam logic             LIMIT_EN = (MAX_BEATS != 0);

  logic             grant;
  logic             grant_nxt;
  logic             addr_owner;
  logic             data_owner;
  logic             lock_q;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_nxt;
  logic             req_cur;
  logic             lock_cur;
  logic             both_req;
  logic             limit_hit;

  // Request/lock of whichever master currently holds the grant
  assign req_cur   = grant ? HBUSREQ_M1 : HBUSREQ_M0;
  assign lock_cur  = grant ? HLOCK_M1   : HLOCK_M0;
  assign both_req  = HBUSREQ_M0 & HBUSREQ_M1;
  assign limit_hit = LIMIT_EN && (beat_cnt >= BEAT_LIM);

`ifdef AHB_ARB_RR_EN
  logic last_winner;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_winner <= DEF_M;
    end else if (HREADY && (grant_nxt != grant)) begin
      last_winner <= grant_nxt;
    end
  end
`endif

  // Arbitration: lock hold, then contention rules, then parking on the default master
  always_comb begin
    grant_nxt = grant;
    if (lock_q && lock_cur) begin
      grant_nxt = grant;
`ifdef AHB_ARB_RR_EN
    end else if (both_req) begin
      grant_nxt = ~last_winner;
`endif
    end else if (both_req && limit_hit) begin
      grant_nxt = ~grant;
    end else if (req_cur) begin
      grant_nxt = grant;
    end else if (HBUSREQ_M0) begin
      grant_nxt = 1'b0;
    end else if (HBUSREQ_M1) begin
      grant_nxt = 1'b1;
    end else begin
      grant_nxt = DEF_M;
    end
  end

  // Beats are counted on the address phase actually on the bus, not on the grant
  always_comb begin
    beat_cnt_nxt = beat_cnt;
    if (grant_nxt != grant) begin
      beat_cnt_nxt = '0;
    end else if (HTRANS[1] && (beat_cnt != CNT_SAT)) begin
      beat_cnt_nxt = beat_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant      <= DEF_M;
      addr_owner <= DEF_M;
      data_owner <= DEF_M;
      beat_cnt   <= '0;
      lock_q     <= 1'b0;
    end else if (HREADY) begin
      grant      <= grant_nxt;
      addr_owner <= grant;
      data_owner <= addr_owner;
      beat_cnt   <= beat_cnt_nxt;
      lock_q     <= lock_cur;
    end
  end

  // Slave-side muxes: address phase follows addr_owner, write data lags by one phase
  always_comb begin
    HADDR  = addr_owner ? HADDR_M1  : HADDR_M0;
    HTRANS = addr_owner ? HTRANS_M1 : HTRANS_M0;
    HWRITE = addr_owner ? HWRITE_M1 : HWRITE_M0;
    HSIZE  = addr_owner ? HSIZE_M1  : HSIZE_M0;
    HWDATA = data_owner ? HWDATA_M1 : HWDATA_M0;
  end

  assign HGRANT_M0 = ~grant;
  assign HGRANT_M1 = grant;
  assign HMASTER   = addr_owner;
  assign HMASTLOCK = lock_q & (HTRANS != 2'b00);

endmodule

// File: tb/tb_ahb_bus_arbiter_2m.sv
// Self-checking bench for ahb_bus_arbiter_2m: randomized traffic against a rule-level model.
module tb_ahb_bus_arbiter_2m;

  localparam int DEF_M   = 0;
  localparam int MAXB    = 8;
  localparam int CNT_SAT = 15;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hready;
  logic        hbusreq [2];
  logic        hlock   [2];
  logic [31:0] haddr   [2];
  logic [1:0]  htrans  [2];
  logic        hwrite  [2];
  logic [2:0]  hsize   [2];
  logic [31:0] hwdata  [2];

  logic        HGRANT_M0, HGRANT_M1, HWRITE, HMASTER, HMASTLOCK;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  int total = 0;
  int bad   = 0;

  // Model state: who holds the grant, who owns address/data phases, beats, lock, last winner
  int m_grant, m_aown, m_down, m_cnt, m_lock, m_last;
  int n_grant, n_aown, n_down, n_cnt, n_lock, n_last;

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter_2m dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HBUSREQ_M0(hbusreq[0]), .HBUSREQ_M1(hbusreq[1]),
    .HLOCK_M0(hlock[0]), .HLOCK_M1(hlock[1]),
    .HGRANT_M0(HGRANT_M0), .HGRANT_M1(HGRANT_M1),
    .HADDR_M0(haddr[0]), .HADDR_M1(haddr[1]),
    .HTRANS_M0(htrans[0]), .HTRANS_M1(htrans[1]),
    .HWRITE_M0(hwrite[0]), .HWRITE_M1(hwrite[1]),
    .HSIZE_M0(hsize[0]), .HSIZE_M1(hsize[1]),
    .HWDATA_M0(hwdata[0]), .HWDATA_M1(hwdata[1]),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(hready), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  task automatic model_reset();
    m_grant = DEF_M; m_aown = DEF_M; m_down = DEF_M;
    m_cnt = 0; m_lock = 0; m_last = DEF_M;
  endtask

  function automatic void model_eval();
    int hold;
    int oth;
    hold = m_grant;
    oth  = 1 - m_grant;
    n_grant = m_grant; n_aown = m_aown; n_down = m_down;
    n_cnt = m_cnt; n_lock = m_lock; n_last = m_last;
    if (hready) begin
      if (m_lock == 1 && hlock[hold]) n_grant = hold;
`ifdef AHB_ARB_RR_EN
      else if (hbusreq[0] && hbusreq[1]) n_grant = 1 - m_last;
`endif
      else if (hbusreq[hold] && hbusreq[oth] && MAXB != 0 && m_cnt >= MAXB) n_grant = oth;
      else if (hbusreq[hold]) n_grant = hold;
      else if (hbusreq[0]) n_grant = 0;
      else if (hbusreq[1]) n_grant = 1;
      else n_grant = DEF_M;
      if (n_grant != m_grant) n_cnt = 0;
      else if (htrans[m_aown] >= 2'd2) n_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
      n_aown = m_grant;
      n_down = m_aown;
      n_lock = hlock[m_grant] ? 1 : 0;
      n_last = (n_grant != m_grant) ? n_grant : m_last;
    end
  endfunction

  // One clock: model sees the inputs as held before the edge, then commits after it
  task automatic step();
    @(negedge HCLK);
    model_eval();
    @(posedge HCLK);
    #1;
    m_grant = n_grant; m_aown = n_aown; m_down = n_down;
    m_cnt = n_cnt; m_lock = n_lock; m_last = n_last;
  endtask

  function automatic logic [73:0] exp_bus();
    return {1'(m_grant == 1), 1'(m_grant == 0), 1'(m_aown),
            1'(m_lock == 1 && htrans[m_aown] != 2'b00),
            htrans[m_aown], hwrite[m_aown], hsize[m_aown], haddr[m_aown], hwdata[m_down]};
  endfunction

  function automatic logic [73:0] got_bus();
    return {HGRANT_M1, HGRANT_M0, HMASTER, HMASTLOCK, HTRANS, HWRITE, HSIZE, HADDR, HWDATA};
  endfunction

  task automatic rand_master(input int x, input bit active);
    haddr[x]  = $urandom;
    hwdata[x] = $urandom;
    hsize[x]  = 3'($urandom_range(0, 2));
    hwrite[x] = 1'($urandom_range(0, 1));
    htrans[x] = active ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    hready  = 1'b1;
    for (int x = 0; x < 2; x++) begin
      hbusreq[x] = 1'b0;
      hlock[x]   = 1'b0;
      rand_master(x, 1'b0);
      htrans[x]  = 2'b00;
    end
    model_reset();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    hready  = 1'b1;
    for (int x = 0; x < 2; x++) begin
      rand_master(x, 1'b1);
      hlock[x] = 1'b1;
    end
    hbusreq[0] = 1'b0;
    hbusreq[1] = 1'b1;
    #1;
    model_reset();
    total++; if (HGRANT_M0 !== 1'b1) begin bad++; $display("FAIL reset_grant_m0: got %b want 1", HGRANT_M0); end
    total++; if (HGRANT_M1 !== 1'b0) begin bad++; $display("FAIL reset_grant_m1: got %b want 0", HGRANT_M1); end
    total++; if (HMASTER !== 1'b0) begin bad++; $display("FAIL reset_hmaster: got %b want 0", HMASTER); end
    total++; if (HMASTLOCK !== 1'b0) begin bad++; $display("FAIL reset_hmastlock: got %b want 0", HMASTLOCK); end
    total++; if (HADDR !== haddr[0]) begin bad++; $display("FAIL reset_haddr: got %h want %h", HADDR, haddr[0]); end
    @(posedge HCLK);
    #1;
    total++; if (HGRANT_M1 !== 1'b0) begin bad++; $display("FAIL reset_held_grant: got %b want 0", HGRANT_M1); end
    HRESETn = 1'b1;
    hbusreq[1] = 1'b0;
    hlock[0] = 1'b0;
    hlock[1] = 1'b0;
  endtask

  task automatic test_m1_only();
    do_reset();
    hbusreq[0] = 1'b0; hbusreq[1] = 1'b1;
    htrans[0]  = 2'b00; htrans[1] = 2'b10;
    haddr[1]   = 32'h2000_0000;
    hwdata[1]  = 32'hA5A5_0001;
    hwdata[0]  = 32'h0000_5A5A;
    step();
    total++; if ({HGRANT_M1, HGRANT_M0, HMASTER} !== 3'b100) begin bad++; $display("FAIL m1_grant_edge1: got %b want 100", {HGRANT_M1, HGRANT_M0, HMASTER}); end
    step();
    total++; if (HMASTER !== 1'b1) begin bad++; $display("FAIL m1_hmaster_edge2: got %b want 1", HMASTER); end
    total++; if (HADDR !== 32'h2000_0000) begin bad++; $display("FAIL m1_haddr: got %h want 20000000", HADDR); end
    total++; if (HWDATA !== 32'h0000_5A5A) begin bad++; $display("FAIL m1_hwdata_old: got %h want 00005a5a", HWDATA); end
    step();
    total++; if (HWDATA !== 32'hA5A5_0001) begin bad++; $display("FAIL m1_hwdata: got %h want a5a50001", HWDATA); end
    hbusreq[1] = 1'b0;
    step();
    total++; if (HGRANT_M0 !== 1'b1) begin bad++; $display("FAIL m1_release_default: got %b want 1", HGRANT_M0); end
  endtask

  task automatic test_burst_limit();
    int  edges;
    bit  found;
    do_reset();
    hbusreq[0] = 1'b1; hbusreq[1] = 1'b1;
    edges = 0; found = 1'b0;
    for (int i = 1; i <= 30 && !found; i++) begin
      rand_master(0, 1'b1); rand_master(1, 1'b1);
      #1;
      total++; if (got_bus() !== exp_bus()) begin bad++; $display("FAIL burst_bus: got %h want %h", got_bus(), exp_bus()); end
      step();
      edges = i;
      if (HGRANT_M1 === 1'b1) found = 1'b1;
    end
    total++; if (!found || edges - 1 != MAXB) begin bad++; $display("FAIL burst_switch_m1: got %0d beats (found=%0d) want %0d", edges - 1, found, MAXB); end
    found = 1'b0;
    for (int i = 1; i <= 30 && !found; i++) begin
      rand_master(0, 1'b1); rand_master(1, 1'b1);
      #1;
      total++; if (got_bus() !== exp_bus()) begin bad++; $display("FAIL burst_back_bus: got %h want %h", got_bus(), exp_bus()); end
      step();
      if (HGRANT_M0 === 1'b1) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL burst_switch_back: got grant_m0=%b want 1 within 30 edges", HGRANT_M0); end
    total++; if (HGRANT_M0 !== 1'(m_grant == 0)) begin bad++; $display("FAIL burst_back_model: got %b want %b", HGRANT_M0, m_grant == 0); end
  endtask

  task automatic test_wait_states();
    logic [31:0] old_wd;
    do_reset();
    hbusreq[0] = 1'b1; hbusreq[1] = 1'b1;
    for (int i = 0; i < MAXB - 1; i++) begin
      rand_master(0, 1'b1); rand_master(1, 1'b1);
      step();
    end
    hready = 1'b0;
    old_wd = hwdata[0];
    for (int w = 0; w < 3; w++) begin
      step();
      total++; if ({HGRANT_M0, HMASTER, HWDATA} !== {1'b1, 1'b0, old_wd}) begin bad++; $display("FAIL wait_pre_hold%0d: got %b %b %h want 1 0 %h", w, HGRANT_M0, HMASTER, HWDATA, old_wd); end
    end
    hready = 1'b1;
    step();
    total++; if (HGRANT_M0 !== 1'b1) begin bad++; $display("FAIL wait_cnt_frozen: got grant_m0=%b want 1", HGRANT_M0); end
    step();
    total++; if ({HGRANT_M1, HMASTER} !== 2'b10) begin bad++; $display("FAIL wait_handover: got %b want 10", {HGRANT_M1, HMASTER}); end
    hready = 1'b0;
    old_wd = hwdata[0];
    for (int w = 0; w < 3; w++) begin
      step();
      total++; if ({HGRANT_M1, HMASTER, HWDATA} !== {1'b1, 1'b0, old_wd}) begin bad++; $display("FAIL wait_mid_hold%0d: got %b %b %h want 1 0 %h", w, HGRANT_M1, HMASTER, HWDATA, old_wd); end
    end
    hready = 1'b1;
    step();
    total++; if ({HMASTER, HWDATA} !== {1'b1, old_wd}) begin bad++; $display("FAIL wait_old_data: got %b %h want 1 %h", HMASTER, HWDATA, old_wd); end
    step();
    total++; if (HWDATA !== hwdata[1]) begin bad++; $display("FAIL wait_new_data: got %h want %h", HWDATA, hwdata[1]); end
  endtask

  task automatic test_lock();
    do_reset();
    hbusreq[0] = 1'b1; hbusreq[1] = 1'b1;
    hlock[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rand_master(0, 1'b1); rand_master(1, 1'b0);
      step();
      total++; if ({HGRANT_M0, HMASTLOCK} !== 2'b11) begin bad++; $display("FAIL lock_hold%0d: got %b want 11", i, {HGRANT_M0, HMASTLOCK}); end
    end
    htrans[0] = 2'b00;
    #1;
    total++; if (HMASTLOCK !== 1'b0) begin bad++; $display("FAIL lock_idle: got %b want 0", HMASTLOCK); end
    step();
    hlock[0] = 1'b0;
    step();
    total++; if (HGRANT_M1 !== 1'b1) begin bad++; $display("FAIL lock_release: got %b want 1", HGRANT_M1); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      hready = ($urandom_range(0, 3) != 0);
      for (int x = 0; x < 2; x++) begin
        hbusreq[x] = ($urandom_range(0, 3) != 0);
        hlock[x]   = ($urandom_range(0, 7) == 0);
        rand_master(x, 1'b0);
      end
      #1;
      total++; if (got_bus() !== exp_bus()) begin bad++; $display("FAIL random_bus%0d: got %h want %h", i, got_bus(), exp_bus()); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hbusreq[0] = 1'b0; hbusreq[1] = 1'b1;
    htrans[1] = 2'b10;
    for (int i = 0; i < 3; i++) step();
    total++; if (HMASTER !== 1'b1) begin bad++; $display("FAIL midrst_pre: got %b want 1", HMASTER); end
    #2;
    HRESETn = 1'b0;
    #1;
    model_reset();
    total++; if ({HGRANT_M0, HGRANT_M1, HMASTER, HWDATA} !== {1'b1, 1'b0, 1'b0, hwdata[0]}) begin bad++; $display("FAIL midrst_async: got %b%b%b %h want 100 %h", HGRANT_M0, HGRANT_M1, HMASTER, HWDATA, hwdata[0]); end
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    hbusreq[1] = 1'b0;
  endtask

`ifdef AHB_ARB_RR_EN
  task automatic test_round_robin();
    do_reset();
    hbusreq[0] = 1'b1; hbusreq[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      htrans[0] = (k % 2 == 0) ? 2'b10 : 2'b00;
      htrans[1] = (k % 2 == 0) ? 2'b10 : 2'b00;
      step();
      total++; if (HGRANT_M1 !== 1'((k % 2) == 0)) begin bad++; $display("FAIL rr_alt%0d: got %b want %b", k, HGRANT_M1, (k % 2) == 0); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_m1_only();
    test_burst_limit();
    test_wait_states();
    test_lock();
    test_reset_mid();
`ifdef AHB_ARB_RR_EN
    test_round_robin();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/ahb_bus_arbiter_2m.md
Name: ahb_bus_arbiter_2m

Overview:
- Two-master AHB arbiter/multiplexer placed between the NfiVe32_SYS CPU (master 0) and a second bus master, e.g. DMA or debug (master 1), in front of the shared AHBlite_sys_0 slave bus.
- Drives HGRANT per master (the CPU's HBUSREQ/HGRANT are no longer tied off) and muxes the address and write-data phases onto the single slave-side bus.
- Supports fixed-priority arbitration plus a burst-length limit (MAX_BEATS) so neither master can starve the other.

Parameters:
DEFAULT_MASTER, 0, master granted when no one requests (0 or 1)
MAX_BEATS, 8, accepted transfers before forced re-arbitration if the other master requests; 0 = no limit
CNT_W, 4, beat counter width; must satisfy 2^CNT_W > MAX_BEATS

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HBUSREQ_M0 / HBUSREQ_M1  in  1  bus request per master
HLOCK_M0 / HLOCK_M1  in  1  locked-sequence request per master
HGRANT_M0 / HGRANT_M1  out  1  grant per master
HADDR_M0 / HADDR_M1  in  32  master address
HTRANS_M0 / HTRANS_M1  in  2  master transfer type
HWRITE_M0 / HWRITE_M1  in  1  master write
HSIZE_M0 / HSIZE_M1  in  3  master size
HWDATA_M0 / HWDATA_M1  in  32  master write data
HADDR  out  32  muxed slave-side address
HTRANS  out  2  muxed slave-side transfer type
HWRITE  out  1  muxed slave-side write
HSIZE  out  3  muxed slave-side size
HWDATA  out  32  muxed slave-side write data
HREADY  in  1  slave-side ready; also broadcast to both masters externally
HMASTER  out  1  current address-phase owner
HMASTLOCK  out  1  current address phase is locked

Behaviour:
- Registers:
  - grant (1b)
  - addr_owner (1b)
  - data_owner (1b)
  - beat_cnt (CNT_W)
  - lock_q (1b)
- Reset values: grant = addr_owner = data_owner = DEFAULT_MASTER; beat_cnt = 0; lock_q = 0. HGRANT_M<DEFAULT_MASTER> = 1 and the other HGRANT = 0. HMASTLOCK = 0.
- HGRANT_Mx = (grant == x). HMASTER = addr_owner.
- Address mux: HADDR/HTRANS/HWRITE/HSIZE are combinational selects by addr_owner. Write-data mux: HWDATA is a combinational select by data_owner.
- Pipeline, on each edge with HREADY = 1:
  - addr_owner <= grant
  - data_owner <= addr_owner
  - lock_q <= HLOCK of grant
- Any cycle with HREADY = 0 holds all of the above.
- Arbitration is evaluated every cycle; grant updates only on edges with HREADY = 1.
  - Locked: if lock_q = 1 and HLOCK of the current grant is still 1, keep grant.
  - Otherwise the next grant is chosen by fixed priority: M0 > M1 among requesting masters.
  - Burst limit: if the current grant holder is still requesting but MAX_BEATS != 0, beat_cnt >= MAX_BEATS, and the other master requests, grant moves to the other master.
  - No requests: grant goes to DEFAULT_MASTER.
- beat_cnt, on an HREADY = 1 edge:
  - Clears to 0 whenever grant changes.
  - Otherwise increments when addr_owner's HTRANS is NONSEQ (10) or SEQ (11).
  - Saturates at 2^CNT_W - 1.
- HMASTLOCK = lock_q & (HTRANS != IDLE).
- Handover latency: HGRANT moves in the same edge that re-arbitrates. The new master's address phase appears on HADDR one HREADY-qualified cycle later. The old master's data phase completes unchanged because data_owner lags.
- Wait states: HREADY held low freezes grant, both owners, beat_cnt and lock_q indefinitely.
- Simultaneous requests from idle: M0 wins. M1 is granted on the edge after M0 drops HBUSREQ, or when the burst limit hits.
- Reset mid-transfer: all state returns to reset values immediately (asynchronous); no transfer is completed.

Optional Feature:
- Macro: AHB_ARB_RR_EN.
- Defined: priority is round-robin. A 1-bit last-winner register (reset = DEFAULT_MASTER) is updated on each grant change. On a contested re-arbitration, the master that is not last-winner gets the grant.
- Undefined: fixed priority M0 > M1; no extra register.

Test Plan:
- Reset with DEFAULT_MASTER = 0 -> HGRANT_M0 = 1, HGRANT_M1 = 0, HMASTER = 0, HMASTLOCK = 0, and HADDR equals HADDR_M0.
- M1 only requests with HREADY = 1 -> HGRANT_M1 = 1 after one edge; HMASTER = 1 one edge later; HADDR = HADDR_M1 = 0x2000_0000; HWDATA from M1 one cycle after that.
- Both request continuously, MAX_BEATS = 8, M0 issuing NONSEQ/SEQ -> grant switches to M1 after exactly 8 accepted M0 beats.
  - Fixed priority: switches back to M0 after 8 M1 beats.
- Mid-handover, slave inserts 3 wait states (HREADY = 0) -> grant, HMASTER, data_owner and beat_cnt stay unchanged for 3 cycles; HWDATA stays from the old owner until its data phase completes.
- M0 asserts HLOCK_M0 with M1 requesting and MAX_BEATS exceeded -> grant stays on M0 and HMASTLOCK = 1 while HTRANS != IDLE; M1 is granted the edge after HLOCK_M0 drops.
- With AHB_ARB_RR_EN, both masters requesting, single-beat NONSEQ+IDLE sequences -> grant alternates M0, M1, M0, M1 on successive arbitration points.
